// File: rtl/controlador_memoria_principal.sv
// Main-memory controller behind the L2 cache.
// Serves block fills as registered read bursts and accepts dirty-block write-backs
// one beat at a time. Only one transaction is in flight at any moment.
// Storage is a word array whose contents start as mem[i] = i.
// The controller reset never touches the stored words.
module controlador_memoria_principal #(
  parameter int ADDR_WIDTH      = 16,
  parameter int DATA_WIDTH      = 16,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int MEM_DEPTH       = 1024,
  parameter int LATENCY         = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_valid,
  output logic                  rdata_last,
  output logic                  done,
  output logic                  busy
);

  localparam int BEAT_W = $clog2(WORDS_PER_BLOCK);
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int MEM_AW = $clog2(MEM_DEPTH);

  localparam logic [BEAT_W-1:0]     LAST_BEAT  = BEAT_W'(WORDS_PER_BLOCK - 1);
  localparam logic [ADDR_WIDTH-1:0] BLOCK_MASK = ADDR_WIDTH'(WORDS_PER_BLOCK - 1);
  localparam logic [CNT_W-1:0]      CNT_LOAD   = CNT_W'(LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_READ_BURST,
    S_WRITE_BURST,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Latched request and progress counters
  logic [ADDR_WIDTH-1:0] r_base;
  logic                  r_write;
  logic [CNT_W-1:0]      r_cnt;
  logic [BEAT_W-1:0]     r_beat;

  // Registered fill outputs
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_rdata_valid;
  logic                  r_rdata_last;

  // Control strobes decoded by the FSM
  logic w_accept;
  logic w_wait_end;
  logic w_rd_beat;
  logic w_wr_beat;
  logic w_last_beat;

  // Word addressing: upper address bits alias onto the array
  logic [ADDR_WIDTH-1:0] w_beat_addr;
  logic [MEM_AW-1:0]     w_mem_idx;
  logic [DATA_WIDTH-1:0] w_word [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] w_rd_word;

  assign w_last_beat = (r_beat == LAST_BEAT);
  assign w_beat_addr = r_base + ADDR_WIDTH'(r_beat);
  assign w_mem_idx   = w_beat_addr[MEM_AW-1:0];
  assign w_rd_word   = w_word[w_mem_idx];

  // Address bits above the array size only alias; they select nothing
  generate
    if (MEM_AW < ADDR_WIDTH) begin : g_alias
      logic w_unused_hi;
      assign w_unused_hi = ^w_beat_addr[ADDR_WIDTH-1:MEM_AW];
    end
  endgenerate

  // Status outputs are pure decodes of the current state
  assign req_ready   = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign wdata_ready = (r_state == S_WRITE_BURST);
  assign done        = (r_state == S_DONE);
  assign rdata       = r_rdata;
  assign rdata_valid = r_rdata_valid;
  assign rdata_last  = r_rdata_last;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and per-cycle control strobes
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_wait_end   = 1'b0;
    w_rd_beat    = 1'b0;
    w_wr_beat    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_accept     = 1'b1;
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_wait_end   = 1'b1;
          w_state_next = r_write ? S_WRITE_BURST : S_READ_BURST;
        end
      end
      S_READ_BURST: begin
        // Every cycle here registers one fill beat; the last beat leaves the
        // state so the next request can be taken while that beat is on the bus.
        w_rd_beat = 1'b1;
        if (w_last_beat) begin
          w_state_next = S_IDLE;
        end
      end
      S_WRITE_BURST: begin
        // The L2 paces the write-back; no valid word means the beat is held.
        if (wdata_valid) begin
          w_wr_beat = 1'b1;
          if (w_last_beat) begin
            w_state_next = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Request latch, latency countdown and beat counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_base  <= '0;
      r_write <= 1'b0;
      r_cnt   <= '0;
      r_beat  <= '0;
    end else begin
      if (w_accept) begin
        r_base  <= req_addr & ~BLOCK_MASK;
        r_write <= req_write;
        r_cnt   <= CNT_LOAD;
      end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end

      if (w_wait_end) begin
        r_beat <= '0;
      end else if (w_rd_beat || w_wr_beat) begin
        r_beat <= r_beat + 1'b1;
      end
    end
  end

  // Registered fill beat: data, valid and last all change on the same edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
      r_rdata_last  <= 1'b0;
    end else begin
      r_rdata_valid <= w_rd_beat;
      r_rdata_last  <= w_rd_beat && w_last_beat;
      if (w_rd_beat) begin
        r_rdata <= w_rd_word;
      end
    end
  end

  // Word storage: each word powers up holding its own index and is only
  // changed by an accepted write-back beat aimed at it.
  generate
    for (genvar gi = 0; gi < MEM_DEPTH; gi++) begin : g_word
      logic [DATA_WIDTH-1:0] r_word = DATA_WIDTH'(gi);

      // Write port for this word
      always_ff @(posedge clock) begin
        if (w_wr_beat && (w_mem_idx == MEM_AW'(gi))) begin
          r_word <= wdata;
        end
      end

      assign w_word[gi] = r_word;
    end
  endgenerate

endmodule

// File: tb/tb_controlador_memoria_principal.sv
// Directed bench for the main-memory controller: fills, write-backs with and
// without stalls, address aliasing, held requests and mid-transaction resets.
module tb_controlador_memoria_principal;

  localparam int ADDR_WIDTH      = 16;
  localparam int DATA_WIDTH      = 16;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int MEM_DEPTH       = 1024;
  localparam int LATENCY         = 3;

  logic                  clock;
  logic                  reset;
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wdata_valid;
  logic                  wdata_ready;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rdata_valid;
  logic                  rdata_last;
  logic                  done;
  logic                  busy;

  int n_checks = 0;
  int n_errors = 0;

  controlador_memoria_principal #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .DATA_WIDTH     (DATA_WIDTH),
    .WORDS_PER_BLOCK(WORDS_PER_BLOCK),
    .MEM_DEPTH      (MEM_DEPTH),
    .LATENCY        (LATENCY)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .wdata      (wdata),
    .wdata_valid(wdata_valid),
    .wdata_ready(wdata_ready),
    .rdata      (rdata),
    .rdata_valid(rdata_valid),
    .rdata_last (rdata_last),
    .done       (done),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Fill from addr; called at a negedge with the controller idle.
  task automatic fill(input string tag, input logic [15:0] addr,
                      input logic [15:0] e0, input logic [15:0] e1,
                      input logic [15:0] e2, input logic [15:0] e3);
    logic [15:0] exp_w [4];
    int n;
    exp_w[0] = e0; exp_w[1] = e1; exp_w[2] = e2; exp_w[3] = e3;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = addr;
    @(negedge clock);
    req_valid = 1'b0;
    check_eq({tag, "_busy"}, 32'(busy), 32'd1);
    n = 0;
    while (!rdata_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    check_eq({tag, "_latency"}, 32'(n), 32'(LATENCY + 1));
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("%s_beat%0d_valid", tag, k), 32'(rdata_valid), 32'd1);
      check_eq($sformatf("%s_beat%0d_data", tag, k), 32'(rdata), 32'(exp_w[k]));
      check_eq($sformatf("%s_beat%0d_last", tag, k), 32'(rdata_last), (k == 3) ? 32'd1 : 32'd0);
      @(negedge clock);
    end
    check_eq({tag, "_valid_end"}, 32'(rdata_valid), 32'd0);
    check_eq({tag, "_ready_end"}, 32'(req_ready), 32'd1);
    $display("fill %s addr=0x%04h beats=%04h %04h %04h %04h", tag, addr, e0, e1, e2, e3);
  endtask

  // Write-back to addr; stalls gap_len cycles after beat gap_after (-1 = none).
  task automatic write_back(input string tag, input logic [15:0] addr,
                            input logic [15:0] d0, input logic [15:0] d1,
                            input logic [15:0] d2, input logic [15:0] d3,
                            input int gap_after, input int gap_len);
    logic [15:0] dw [4];
    int n;
    dw[0] = d0; dw[1] = d1; dw[2] = d2; dw[3] = d3;
    req_valid   = 1'b1;
    req_write   = 1'b1;
    req_addr    = addr;
    // Junk beat offered before the burst opens; it must not be written.
    wdata_valid = 1'b1;
    wdata       = 16'hDEAD;
    @(negedge clock);
    req_valid = 1'b0;
    n = 0;
    while (!wdata_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    check_eq({tag, "_wready_latency"}, 32'(n), 32'(LATENCY));
    for (int b = 0; b < 4; b++) begin
      wdata_valid = 1'b1;
      wdata       = dw[b];
      @(negedge clock);
      check_eq($sformatf("%s_done_after_beat%0d", tag, b), 32'(done), (b == 3) ? 32'd1 : 32'd0);
      if (b == gap_after) begin
        wdata_valid = 1'b0;
        wdata       = 16'hBEEF;
        for (int g = 0; g < gap_len; g++) begin
          @(negedge clock);
          check_eq($sformatf("%s_gap%0d_done", tag, g), 32'(done), 32'd0);
          check_eq($sformatf("%s_gap%0d_wready", tag, g), 32'(wdata_ready), 32'd1);
        end
      end
    end
    wdata_valid = 1'b0;
    @(negedge clock);
    check_eq({tag, "_done_cleared"}, 32'(done), 32'd0);
    check_eq({tag, "_ready_end"}, 32'(req_ready), 32'd1);
    req_write = 1'b0;
    $display("write-back %s addr=0x%04h data=%04h %04h %04h %04h", tag, addr, d0, d1, d2, d3);
  endtask

  initial begin
    logic [15:0] got_q [$];
    logic [15:0] exp4 [8];
    int ready_at;
    int acc;
    int n;

    reset       = 1'b0;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_addr    = '0;
    wdata       = '0;
    wdata_valid = 1'b0;

    // Reset state
    @(negedge clock);
    @(negedge clock);
    check_eq("rst_rdata", 32'(rdata), 32'd0);
    check_eq("rst_rvalid", 32'(rdata_valid), 32'd0);
    check_eq("rst_rlast", 32'(rdata_last), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_wready", 32'(wdata_ready), 32'd0);
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    $display("reset released");

    // 1: fill from a mid-block address
    fill("t1", 16'h0005, 16'h0004, 16'h0005, 16'h0006, 16'h0007);

    // 2: back-to-back write-back then fill from inside the same block
    write_back("t2", 16'h0010, 16'hA000, 16'hA001, 16'hA002, 16'hA003, -1, 0);
    fill("t2", 16'h0012, 16'hA000, 16'hA001, 16'hA002, 16'hA003);

    // 3: write-back with a two-cycle stall between beats 1 and 2
    write_back("t3", 16'h0020, 16'hC000, 16'hC001, 16'hC002, 16'hC003, 1, 2);
    fill("t3", 16'h0020, 16'hC000, 16'hC001, 16'hC002, 16'hC003);

    // 4: aliased fill with a second request held during the burst
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 16'h0404;
    @(negedge clock);
    req_addr = 16'h000C;
    check_eq("t4_ready_in_wait", 32'(req_ready), 32'd0);
    ready_at = -1;
    acc      = 0;
    for (int c = 0; c < 30; c++) begin
      if (rdata_valid) got_q.push_back(rdata);
      if (req_valid && req_ready) begin
        if (ready_at < 0) ready_at = got_q.size();
        acc++;
      end
      @(negedge clock);
      if (acc > 0) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    check_eq("t4_accepts", 32'(acc), 32'd1);
    check_eq("t4_ready_after_beats", 32'(ready_at), 32'd4);
    check_eq("t4_beat_count", 32'(got_q.size()), 32'd8);
    exp4 = '{16'h0004, 16'h0005, 16'h0006, 16'h0007, 16'h000C, 16'h000D, 16'h000E, 16'h000F};
    for (int k = 0; k < 8; k++) begin
      check_eq($sformatf("t4_word%0d", k), (k < got_q.size()) ? 32'(got_q[k]) : 32'hFFFF_FFFF, 32'(exp4[k]));
    end
    $display("fill t4 addr=0x0404 then held request addr=0x000C, %0d beats", got_q.size());

    // 5: reset in the middle of a fill
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 16'h0018;
    @(negedge clock);
    req_valid = 1'b0;
    n = 0;
    while (!rdata_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    check_eq("t5_beat0", 32'(rdata), 32'h0018);
    @(negedge clock);
    check_eq("t5_beat1", 32'(rdata), 32'h0019);
    reset = 1'b0;
    #1;
    check_eq("t5_rst_rdata", 32'(rdata), 32'd0);
    check_eq("t5_rst_rvalid", 32'(rdata_valid), 32'd0);
    check_eq("t5_rst_rlast", 32'(rdata_last), 32'd0);
    check_eq("t5_rst_busy", 32'(busy), 32'd0);
    check_eq("t5_rst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    $display("reset during fill addr=0x0018");
    fill("t5", 16'h0008, 16'h0008, 16'h0009, 16'h000A, 16'h000B);

    // 6: reset after two write-back beats
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 16'h0030;
    @(negedge clock);
    req_valid = 1'b0;
    n = 0;
    while (!wdata_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    check_eq("t6_wready_latency", 32'(n), 32'(LATENCY));
    wdata_valid = 1'b1;
    wdata       = 16'hB000;
    @(negedge clock);
    wdata = 16'hB001;
    @(negedge clock);
    wdata_valid = 1'b0;
    check_eq("t6_done_before_rst", 32'(done), 32'd0);
    reset = 1'b0;
    #1;
    check_eq("t6_rst_done", 32'(done), 32'd0);
    check_eq("t6_rst_busy", 32'(busy), 32'd0);
    check_eq("t6_rst_wready", 32'(wdata_ready), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    req_write = 1'b0;
    @(negedge clock);
    check_eq("t6_no_done", 32'(done), 32'd0);
    $display("reset during write-back addr=0x0030 after 2 beats");
    fill("t6", 16'h0030, 16'hB000, 16'hB001, 16'h0032, 16'h0033);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/controlador_memoria_principal.md
Name: controlador_memoria_principal

Overview:
Main-memory backing store and controller directly downstream of the L2 cache in the memory hierarchy.
- Serves L2 misses with block fills (burst reads) and accepts dirty-block write-backs (burst writes).
- Owns the word array, models a fixed access latency, and transfers one word per beat.
- One transaction in flight at a time.

Parameters:
ADDR_WIDTH, 16, width of the word address
DATA_WIDTH, 16, width of one word
WORDS_PER_BLOCK, 4, beats per transaction; must be a power of 2 and at least 2
MEM_DEPTH, 1024, number of words stored; must be a power of 2
LATENCY, 3, wait cycles between request acceptance and the first beat; must be at least 1

Ports:
clock  in  1  system clock; rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  L2 presents a request
req_ready  out  1  controller can accept a request
req_write  in  1  1 = write-back, 0 = fill
req_addr  in  ADDR_WIDTH  any word address inside the target block
wdata  in  DATA_WIDTH  write-back beat data
wdata_valid  in  1  wdata is valid
wdata_ready  out  1  controller accepts a write beat
rdata  out  DATA_WIDTH  fill beat data
rdata_valid  out  1  rdata is valid this cycle
rdata_last  out  1  final fill beat
done  out  1  one-cycle pulse when a write-back completes
busy  out  1  a transaction is in progress (state is not IDLE)

Behaviour:
- Storage:
  - mem[MEM_DEPTH] is initialised at time 0 to mem[i] = i, truncated to DATA_WIDTH.
  - reset never modifies memory contents.
- Address mapping:
  - base = req_addr with the low log2(WORDS_PER_BLOCK) bits cleared, latched on acceptance.
  - Beat k accesses mem[(base + k) mod MEM_DEPTH]; upper address bits alias.
- Reset (reset = 0, asynchronous):
  - State goes to IDLE; beat and latency counters clear.
  - rdata = 0; rdata_valid, rdata_last, done, busy, wdata_ready = 0.
  - req_ready = 1, because it is decoded from state == IDLE.
- States: IDLE, WAIT, READ_BURST, WRITE_BURST, DONE.
  - IDLE: req_ready = 1. On a clock edge with req_valid = 1, latch base and req_write, load the counter with LATENCY-1, go to WAIT.
  - WAIT: counter decrements each cycle. At 0, go to READ_BURST if req_write = 0, else WRITE_BURST; beat = 0. Lasts exactly LATENCY cycles.
  - READ_BURST:
    - rdata, rdata_valid and rdata_last are registered; the burst has no backpressure and L2 must accept every beat.
    - Beats occupy WORDS_PER_BLOCK contiguous cycles.
    - The first rdata_valid is visible after edge LATENCY+1, counting the acceptance edge as edge 0.
    - rdata_last = 1 only on beat WORDS_PER_BLOCK-1. The next edge returns to IDLE and clears rdata_valid.
  - WRITE_BURST:
    - wdata_ready = 1 (combinational from state).
    - On each edge with wdata_valid = 1, write mem[base+beat] = wdata and increment beat.
    - When wdata_valid = 0, the controller stalls indefinitely with beat held.
    - After the edge that writes beat WORDS_PER_BLOCK-1, go to DONE.
  - DONE: done = 1 for exactly one cycle, then IDLE.
- busy = 1 in WAIT, READ_BURST, WRITE_BURST and DONE.
- req_valid outside IDLE is ignored (req_ready = 0); the L2 holds the request until accepted.
  - Minimum gap between acceptances: LATENCY + WORDS_PER_BLOCK + 1 cycles for a fill.
- wdata_valid outside WRITE_BURST is ignored and no write occurs.
- Reset mid-transaction:
  - Write-back beats already written stay in memory.
  - Pending fill beats are abandoned.
  - No done pulse is generated.
- A read of a word in the cycle it is written is not possible; only one transaction is in flight.

Test Plan:
1. Fill with req_addr = 0x0005, defaults: accept at edge 0 -> rdata_valid high after edges 4..7 with rdata 0x0004, 0x0005, 0x0006, 0x0007; rdata_last only on 0x0007; req_ready high again the cycle after.
2. Write-back to 0x0010 with beats 0xA000..0xA003 on consecutive cycles, then fill from 0x0012 -> done pulses once for 1 cycle; fill returns 0xA000, 0xA001, 0xA002, 0xA003.
3. Write-back to 0x0020 with wdata_valid low for 2 cycles between beats 1 and 2 -> beat count holds during gap; mem[0x20..0x23] holds the sent data; done after the 4th accepted beat only.
4. Fill from 0x0404 (aliases to word 0x004) -> rdata 0x0004..0x0007; a second req_valid held during the burst is accepted only when state returns to IDLE.
5. Assert reset = 0 mid-fill after beat 1 -> outputs go to 0 immediately (asynchronous); req_ready = 1; a subsequent fill of 0x0008 returns 0x0008..0x000B normally.
6. Reset after 2 of 4 write-back beats to 0x0030 with data 0xB000, 0xB001 -> no done pulse; a later fill of 0x0030 returns 0xB000, 0xB001, 0x0032, 0x0033.
